bcd_scan_decoder: RTL and testbench

- Parametrised, time-multiplexed successor to the team's 4-bit BCD-to-decimal decoder.
- Holds NUM_DIGITS packed BCD digits in a double-buffered display register.
- Scans the digits one at a time with a prescaler and drives a shared registered 10-line decimal bus plus a one-hot digit select.
- Sits between counter/arith blocks producing BCD and board display or indicator drivers.

---
 rtl/bcd_scan_decoder_pkg.sv | 29 ++
 rtl/bcd_scan_decoder_if.sv | 32 +++
 rtl/bcd_scan_decoder_prescaler.sv | 52 +++++
 rtl/bcd_scan_decoder.sv | 100 ++++++++++
 tb/tb_bcd_scan_decoder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bcd_scan_decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_pkg : shared widths, types and BCD decode helpers for bcd_scan_decoder
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [DEC_W-1:0] dec_t;

  // Active-high one-hot; codes 10..15 decode to no line at all.
  function automatic dec_t bcd_to_dec(input bcd_t code);
    dec_t dec;
    dec = '0;
    if (code <= 4'd9) begin
      dec[code] = 1'b1;
    end
    return dec;
  endfunction

  function automatic logic is_bcd_invalid(input bcd_t code);
    return (code > 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_decoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_scan_decoder_if : load handshake and scanned display bus
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
interface bcd_scan_decoder_if
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);

  logic [BCD_W*NUM_DIGITS-1:0] bcd_in;
  logic                        load;
  logic                        load_ack;
  logic [DEC_W-1:0]            y;
  logic [NUM_DIGITS-1:0]       dig_sel;
  logic [IDX_W-1:0]            digit_idx;
  logic                        invalid;

  modport master (
    output bcd_in, load,
    input  load_ack, y, dig_sel, digit_idx, invalid
  );

  modport slave (
    input  bcd_in, load,
    output load_ack, y, dig_sel, digit_idx, invalid
  );

endinterface
`default_nettype wire

// File: rtl/bcd_scan_decoder_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_scan_prescaler : dwell-time prescaler and digit scan index
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module bcd_scan_prescaler #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             terminal_o,
  output logic             frame_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             terminal;
  logic             last_digit;

  always_comb begin
    terminal   = (cnt_q == CNT_LAST);
    last_digit = (idx_q == IDX_LAST);
    cnt_d      = terminal ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (terminal) begin
      idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign terminal_o = terminal;
  assign frame_o    = terminal & last_digit;
  assign idx_o      = idx_q;

endmodule
`default_nettype wire

// File: rtl/bcd_scan_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_scan_decoder : double-buffered, time-multiplexed BCD-to-decimal decoder
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module bcd_scan_decoder
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_scan_decoder_if.slave  dec_if
);

  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int                    DATA_W   = BCD_W * NUM_DIGITS;
  localparam logic [DEC_W-1:0]      Y_IDLE   = (ACTIVE_LOW != 0) ? {DEC_W{1'b1}} : {DEC_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic             terminal;
  logic             frame;
  logic [IDX_W-1:0] idx;

  bcd_scan_prescaler #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .IDX_W      (IDX_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .terminal_o (terminal),
    .frame_o    (frame),
    .idx_o      (idx)
  );

  logic [DATA_W-1:0]     staged_q, staged_d;
  logic                  staged_valid_q, staged_valid_d;
  logic [DATA_W-1:0]     display_q, display_d;
  logic                  load_ack_q, load_ack_d;
  logic [DEC_W-1:0]      y_q, y_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [IDX_W-1:0]      digit_idx_q;
  logic                  invalid_q, invalid_d;

  logic                  commit;
  bcd_t                  cur_digit;
  dec_t                  dec;
  logic [NUM_DIGITS-1:0] sel;

  // Commit only at the frame boundary so a frame never mixes old and new data.
  always_comb begin
    commit         = frame & terminal & staged_valid_q;
    display_d      = commit ? staged_q : display_q;
    staged_d       = dec_if.load ? dec_if.bcd_in : staged_q;
    staged_valid_d = dec_if.load | (staged_valid_q & ~commit);
    load_ack_d     = commit;
  end

  always_comb begin
    cur_digit = display_q[int'(idx) * BCD_W +: BCD_W];
    dec       = bcd_to_dec(cur_digit);
    sel       = NUM_DIGITS'(1) << idx;
    y_d       = (ACTIVE_LOW != 0) ? ~dec : dec;
    dig_sel_d = (ACTIVE_LOW != 0) ? ~sel : sel;
    invalid_d = is_bcd_invalid(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staged_q       <= '0;
      staged_valid_q <= 1'b0;
      display_q      <= '0;
      load_ack_q     <= 1'b0;
      y_q            <= Y_IDLE;
      dig_sel_q      <= SEL_IDLE;
      digit_idx_q    <= '0;
      invalid_q      <= 1'b0;
    end else begin
      staged_q       <= staged_d;
      staged_valid_q <= staged_valid_d;
      display_q      <= display_d;
      load_ack_q     <= load_ack_d;
      y_q            <= y_d;
      dig_sel_q      <= dig_sel_d;
      digit_idx_q    <= idx;
      invalid_q      <= invalid_d;
    end
  end

  assign dec_if.load_ack  = load_ack_q;
  assign dec_if.y         = y_q;
  assign dec_if.dig_sel   = dig_sel_q;
  assign dec_if.digit_idx = digit_idx_q;
  assign dec_if.invalid   = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bcd_scan_decoder : directed bench for the 4-digit and 1-digit configurations
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_bcd_scan_decoder;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  int nk;
  int n_ack;

  bcd_scan_decoder_if #(.NUM_DIGITS(4)) if0 ();
  bcd_scan_decoder_if #(.NUM_DIGITS(1)) if1 ();

  bcd_scan_decoder #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .dec_if (if0.slave)
  );

  bcd_scan_decoder #(.NUM_DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(0)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .dec_if (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan cycle of dut0: optionally pulse load, then check the full output
  // word against the digit the scan position should be showing from disp.
  task automatic cyc(input string tag, input bit ld, input logic [15:0] data,
                     input logic [15:0] disp, input bit ack);
    int         idx;
    logic [3:0] v;
    logic [1:0] ei;
    logic [3:0] esel;
    logic [9:0] ey;
    if0.load   = ld;
    if0.bcd_in = data;
    tick();
    if0.load = 1'b0;
    k++;
    idx  = ((k - 1) / 4) % 4;
    ei   = 2'(idx);
    v    = disp[idx*4 +: 4];
    esel = 4'hF & ~(4'd1 << ei);
    ey   = (v <= 4'd9) ? ~(10'd1 << v) : 10'h3FF;
    if (if0.load_ack === 1'b1) n_ack++;
    check(tag,
          {14'd0, if0.load_ack, if0.invalid, if0.digit_idx, if0.dig_sel, if0.y},
          {14'd0, ack, (v > 4'd9), ei, esel, ey});
  endtask

  initial begin
    rst        = 1'b1;
    if0.load   = 1'b0;
    if0.bcd_in = '0;
    if1.load   = 1'b0;
    if1.bcd_in = '0;
    repeat (3) tick();
    check("rst_dut0", {14'd0, if0.load_ack, if0.invalid, if0.digit_idx, if0.dig_sel, if0.y},
          {14'd0, 1'b0, 1'b0, 2'd0, 4'hF, 10'h3FF});
    check("rst_dut1", {17'd0, if1.load_ack, if1.invalid, if1.digit_idx, if1.dig_sel, if1.y}, 32'd0);
    rst = 1'b0;
    k   = 0;

    // Idle: every digit shows 0, dig_sel walks, no ack.
    while (k < 40) cyc("t1_idle", 1'b0, 16'h0, 16'h0000, 1'b0);

    // Load 9371 at edge 42, committed at frame boundary edge 48.
    while (k < 48) begin
      nk = k + 1;
      cyc("t2_pre", nk == 42, 16'h9371, 16'h0000, nk == 48);
    end
    while (k < 64) begin
      cyc("t2_post", 1'b0, 16'h0, 16'h9371, 1'b0);
      if (k == 49) check("t2_d0_y1", {22'd0, if0.y}, {22'd0, 10'h3FD});
      if (k == 53) check("t2_d1_y7", {22'd0, if0.y}, {22'd0, 10'h37F});
      if (k == 57) check("t2_d2_y3", {22'd0, if0.y}, {22'd0, 10'h3F7});
      if (k == 61) check("t2_d3_y9", {22'd0, if0.y}, {22'd0, 10'h1FF});
    end

    // Invalid codes A and F blank the bus and raise invalid.
    while (k < 80) begin
      nk = k + 1;
      cyc("t3_pre", nk == 66, 16'hF0A5, 16'h9371, nk == 80);
    end
    while (k < 96) begin
      cyc("t3_post", 1'b0, 16'h0, 16'hF0A5, 1'b0);
      if (k == 81) check("t3_d0_y5", {21'd0, if0.invalid, if0.y}, {21'd0, 1'b0, 10'h3DF});
      if (k == 85) check("t3_d1_inv", {21'd0, if0.invalid, if0.y}, {21'd0, 1'b1, 10'h3FF});
      if (k == 89) check("t3_d2_y0", {21'd0, if0.invalid, if0.y}, {21'd0, 1'b0, 10'h3FE});
      if (k == 93) check("t3_d3_inv", {21'd0, if0.invalid, if0.y}, {21'd0, 1'b1, 10'h3FF});
    end

    // Last write wins; a load on the boundary edge waits for the next frame.
    n_ack = 0;
    while (k < 112) begin
      nk = k + 1;
      cyc("t4_a", (nk == 98) || (nk == 100) || (nk == 112),
          (nk == 98) ? 16'h1111 : ((nk == 100) ? 16'h2222 : 16'h3333),
          16'hF0A5, nk == 112);
    end
    while (k < 128) begin
      nk = k + 1;
      cyc("t4_b", 1'b0, 16'h0, 16'h2222, nk == 128);
    end
    while (k < 144) cyc("t4_c", 1'b0, 16'h0, 16'h3333, 1'b0);
    check("t4_ack_count", n_ack, 2);

    // Reset with 5555 pending; a load during reset is ignored too.
    while (k < 153) begin
      nk = k + 1;
      cyc("t5_pre", nk == 150, 16'h5555, 16'h3333, 1'b0);
    end
    rst        = 1'b1;
    if0.load   = 1'b1;
    if0.bcd_in = 16'h7777;
    tick();
    if0.load = 1'b0;
    check("t5_rst", {14'd0, if0.load_ack, if0.invalid, if0.digit_idx, if0.dig_sel, if0.y},
          {14'd0, 1'b0, 1'b0, 2'd0, 4'hF, 10'h3FF});
    check("t5_rst_dut1", {17'd0, if1.load_ack, if1.invalid, if1.digit_idx, if1.dig_sel, if1.y}, 32'd0);
    tick();
    rst   = 1'b0;
    k     = 0;
    n_ack = 0;
    while (k < 40) cyc("t5_post", 1'b0, 16'h0, 16'h0000, 1'b0);
    check("t5_no_ack", n_ack, 0);

    // Single digit, no prescale, active-high outputs.
    check("t6_sel", {31'd0, if1.dig_sel}, 32'd1);
    check("t6_y0", {22'd0, if1.y}, {22'd0, 10'h001});
    if1.load   = 1'b1;
    if1.bcd_in = 4'h6;
    tick();
    if1.load = 1'b0;
    check("t6_ack_early", {31'd0, if1.load_ack}, 32'd0);
    tick();
    check("t6_ack", {31'd0, if1.load_ack}, 32'd1);
    check("t6_y_old", {22'd0, if1.y}, {22'd0, 10'h001});
    tick();
    check("t6_ack_clear", {31'd0, if1.load_ack}, 32'd0);
    check("t6_y6", {21'd0, if1.invalid, if1.y}, {21'd0, 1'b0, 10'h040});
    check("t6_sel_hold", {31'd0, if1.dig_sel}, 32'd1);
    if1.load   = 1'b1;
    if1.bcd_in = 4'hC;
    tick();
    if1.load = 1'b0;
    tick();
    tick();
    check("t6_invalid", {21'd0, if1.invalid, if1.y}, {21'd0, 1'b1, 10'h000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
